stopwatch_timebase: RTL

Upstream timing stage of the stopwatch. It divides the system clock down to centiseconds and keeps the centisecond (0-99) and second (0-59) fields. A three-state run/pause/idle controller driven by single-cycle button pulses gates the count. It emits a single-cycle `minute_tick` on every 59.99 -> 00.00 rollover, and that pulse drives the `tick` input of the minutes counter.

---
 rtl/stopwatch_timebase.sv | 112 +++++++++++
 1 files changed

// File: rtl/stopwatch_timebase.sv
// Stopwatch timebase: divides clk down to centiseconds, keeps the centis/seconds
// fields under a run/pause/idle controller, and pulses minute_tick on 59.99 -> 00.00.
module stopwatch_timebase #(
  parameter int CLKS_PER_CS = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  output logic       running,
  output logic [1:0] state,
  output logic [7:0] centis,
  output logic [7:0] seconds,
  output logic       minute_tick
);

  localparam int PS_W = (CLKS_PER_CS > 1) ? $clog2(CLKS_PER_CS) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLKS_PER_CS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic [7:0]      centis_q, centis_d;
  logic [7:0]      seconds_q, seconds_d;
  logic            minute_tick_q, minute_tick_d;

  logic            zero_fields;
  logic            cs_tick;
  logic            centis_wrap;
  logic            seconds_wrap;

  // Controller: clear beats start_stop in PAUSE; in IDLE start_stop wins.
  always_comb begin
    state_d     = state_q;
    zero_fields = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (start_stop) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (clear) begin
          state_d     = ST_IDLE;
          zero_fields = 1'b1;
        end else if (start_stop) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cs_tick      = (state_q == ST_RUN) && (ps_q == PS_MAX);
  assign centis_wrap  = (centis_q == 8'd99);
  assign seconds_wrap = (seconds_q == 8'd59);

  // Counting follows the state held before the edge, so a tick on the pausing
  // edge still counts and a resume picks up the partial centisecond.
  always_comb begin
    ps_d          = ps_q;
    centis_d      = centis_q;
    seconds_d     = seconds_q;
    minute_tick_d = cs_tick && centis_wrap && seconds_wrap;
    if (zero_fields) begin
      ps_d      = '0;
      centis_d  = 8'd0;
      seconds_d = 8'd0;
    end else if (state_q == ST_RUN) begin
      if (cs_tick) begin
        ps_d = '0;
        if (centis_wrap) begin
          centis_d  = 8'd0;
          seconds_d = seconds_wrap ? 8'd0 : seconds_q + 8'd1;
        end else begin
          centis_d = centis_q + 8'd1;
        end
      end else begin
        ps_d = ps_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ps_q          <= '0;
      centis_q      <= 8'd0;
      seconds_q     <= 8'd0;
      minute_tick_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ps_q          <= ps_d;
      centis_q      <= centis_d;
      seconds_q     <= seconds_d;
      minute_tick_q <= minute_tick_d;
    end
  end

  assign state       = state_q;
  assign running     = (state_q == ST_RUN);
  assign centis      = centis_q;
  assign seconds     = seconds_q;
  assign minute_tick = minute_tick_q;

endmodule
